// File: rtl/alu_result_fifo.sv
// FWFT result FIFO after the ALU: buffers Y with {Z,N,C,V}.
// Optional sticky C/V tracking via ALU_STICKY_FLAGS_EN.
module alu_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_y,
  input  logic [3:0]         in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic [3:0]         out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic               sticky_c,
  output logic               sticky_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 4;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic [EW-1:0] head;

  assign empty     = (count == '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];

  // Head entry, masked to zero while the FIFO is empty
  always_comb begin
    out_y     = '0;
    out_flags = '0;
    if (!empty) begin
      out_y     = head[EW-1:4];
      out_flags = head[3:0];
    end
  end

  // Storage write; contents need no reset since outputs are masked
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= {in_y, in_flags};
  end

  // Pointers and occupancy; clear overrides any same-cycle push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push && !pop): count <= count + CW'(1);
        (pop && !push): count <= count - CW'(1);
        default:        count <= count;
      endcase
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  // Accumulate carry/overflow over every accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else if (clear) begin
      sticky_c <= 1'b0;
      sticky_v <= 1'b0;
    end else if (push) begin
      sticky_c <= sticky_c | in_flags[1];
      sticky_v <= sticky_v | in_flags[0];
    end
  end
`else
  assign sticky_c = 1'b0;
  assign sticky_v = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed steps then random traffic
// compared against a queue model.
module tb_alu_result_fifo;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_y;
  logic [3:0]   in_flags;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [3:0]   out_flags;
  logic [2:0]   count;
  logic         sticky_c;
  logic         sticky_v;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic sc;
  logic sv;

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_y(in_y),
    .in_flags(in_flags),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_flags(out_flags),
    .count(count),
    .sticky_c(sticky_c),
    .sticky_v(sticky_v)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] hd;
    hd = 8'h00;
    if (q.size() != 0) hd = q[0];
    chk("count", {5'b0, count}, 8'(q.size()));
    chk("out_valid", {7'b0, out_valid}, {7'b0, q.size() != 0});
    chk("in_ready", {7'b0, in_ready}, {7'b0, q.size() != D});
    chk("out_y", {4'b0, out_y}, {4'b0, hd[7:4]});
    chk("out_flags", {4'b0, out_flags}, {4'b0, hd[3:0]});
    chk("sticky_c", {7'b0, sticky_c}, {7'b0, sc});
    chk("sticky_v", {7'b0, sticky_v}, {7'b0, sv});
  endtask

  task automatic cycle(input logic cl, input logic iv,
                       input logic [3:0] y, input logic [3:0] f,
                       input logic ordy);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    clear = cl;
    in_valid = iv;
    in_y = y;
    in_flags = f;
    out_ready = ordy;
    #1 check_model();
    do_push = iv && (q.size() < D);
    do_pop = ordy && (q.size() > 0);
    @(posedge clk);
    if (cl) begin
      q.delete();
      sc = 1'b0;
      sv = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({y, f});
`ifdef ALU_STICKY_FLAGS_EN
      if (do_push) begin
        sc = sc | f[1];
        sv = sv | f[0];
      end
`endif
    end
  endtask

  initial begin
    sc = 1'b0;
    sv = 1'b0;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_y = '0;
    in_flags = '0;
    out_ready = 1'b0;
    #12 check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // two pushes, consumer stalled
    cycle(0, 1, 4'b0110, 4'b0000, 0);
    cycle(0, 1, 4'b1100, 4'b0100, 0);
    cycle(0, 0, 4'h0, 4'h0, 0);

    // async reset mid-stream
    @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    sc = 1'b0;
    sv = 1'b0;
    #1 check_model();
    @(negedge clk);
    rst_n = 1'b1;

    // fill, overfill, drain
    for (int i = 1; i <= 5; i++)
      cycle(0, 1, 4'(i), 4'(i), 0);
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 4'h0, 4'h0, 1);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 4'(i + 8), 4'h8, 0);
    cycle(0, 1, 4'hf, 4'hf, 1);
    cycle(0, 0, 4'h0, 4'h0, 0);
    cycle(1, 0, 4'h0, 4'h0, 0);

    // wrap at steady occupancy 1
    cycle(0, 1, 4'h3, 4'h1, 0);
    for (int i = 0; i < 6; i++)
      cycle(0, 1, 4'(i + 10), 4'(i), 1);
    cycle(0, 0, 4'h0, 4'h0, 1);

    // clear beats same-cycle push and pop
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 4'(i + 5), 4'h0, 0);
    cycle(1, 1, 4'h9, 4'h9, 1);

    // sticky flags
    cycle(0, 1, 4'h1, 4'b0010, 0);
    cycle(0, 1, 4'h2, 4'b0001, 1);
    cycle(0, 0, 4'h0, 4'h0, 1);
    cycle(1, 0, 4'h0, 4'h0, 0);

    // empty with push and out_ready
    cycle(0, 1, 4'h7, 4'h2, 1);

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(($urandom_range(0, 29) == 0),
            1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom));
    cycle(0, 0, 4'h0, 4'h0, 0);
    @(negedge clk);
    #1 check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
